// File: rtl/clock_divider_prog.sv
// Programmable clock divider: produces a divided clock and a one-cycle Tick
// enable from Clock_in. A new divisor is staged as pending and only takes
// over at a period boundary (wrap or Restart), so Clock_out never glitches.
module clock_divider_prog #(
  parameter int WIDTH     = 16,
  parameter int RESET_DIV = 4
) (
  input  logic             Clock_in,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic             Restart,
  input  logic [WIDTH-1:0] Div_value,
  input  logic             Div_load,
  output logic             Div_busy,
  output logic             Div_ack,
  output logic             Clock_out,
  output logic             Tick
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] N_RST = (RESET_DIV < 2) ? TWO : WIDTH'(RESET_DIV);

  // Divisors below 2 cannot form a high and a low phase; force them to 2.
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    return (v < TWO) ? TWO : v;
  endfunction

  logic [WIDTH-1:0] cnt, n_act, n_pend;
  logic             pend;

  logic             wrap, apply;
  logic [WIDTH-1:0] n_nxt, cnt_nx, hi_len;

  // Next-state terms: divisor in force for the next period and the new count.
  always_comb begin
    wrap   = (cnt == n_act - ONE);
    apply  = pend && (Restart || (Enable && wrap));
    n_nxt  = apply ? n_pend : n_act;
    hi_len = n_nxt - (n_nxt >> 1);
    cnt_nx = cnt;
    if (Restart)     cnt_nx = n_nxt - ONE;
    else if (Enable) cnt_nx = wrap ? '0 : cnt + ONE;
  end

  // Counter, divisor staging and registered outputs derived from the new count.
  always_ff @(posedge Clock_in or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt       <= N_RST - ONE;
      n_act     <= N_RST;
      n_pend    <= N_RST;
      pend      <= 1'b0;
      Clock_out <= 1'b0;
      Tick      <= 1'b0;
      Div_ack   <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      n_act   <= n_nxt;
      Div_ack <= apply;
      if (Restart) begin
        Clock_out <= 1'b0;
        Tick      <= 1'b0;
      end else if (Enable) begin
        Clock_out <= (cnt_nx < hi_len);
        Tick      <= (cnt_nx == '0);
      end else begin
        Tick      <= 1'b0;
      end
      // A load on the applying edge becomes the next pending value.
      if (Div_load) begin
        n_pend <= clamp(Div_value);
        pend   <= 1'b1;
      end else if (apply) begin
        pend   <= 1'b0;
      end
    end
  end

  assign Div_busy = pend;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog with hand-computed expected sequences.
module tb_clock_divider_prog;

  localparam int WIDTH = 16;

  logic             Clock_in = 1'b0;
  logic             Reset_n, Enable, Restart, Div_load;
  logic [WIDTH-1:0] Div_value;
  logic             Div_busy, Div_ack, Clock_out, Tick;

  int n_cmp = 0;
  int n_mis = 0;

  clock_divider_prog #(.WIDTH(WIDTH), .RESET_DIV(4)) dut (
    .Clock_in (Clock_in),
    .Reset_n  (Reset_n),
    .Enable   (Enable),
    .Restart  (Restart),
    .Div_value(Div_value),
    .Div_load (Div_load),
    .Div_busy (Div_busy),
    .Div_ack  (Div_ack),
    .Clock_out(Clock_out),
    .Tick     (Tick)
  );

  always #5 Clock_in = ~Clock_in;

  task automatic step();
    @(posedge Clock_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic o, input logic e);
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic chki(input string tag, input int o, input int e);
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  initial begin
    logic [11:0] e_clk, e_tick, e_ack, e_busy;
    int per, hi, busy_cnt;

    Reset_n = 1'b0; Enable = 1'b0; Restart = 1'b0; Div_load = 1'b0; Div_value = '0;
    step(); step();
    chk("rst_clk",  Clock_out, 1'b0);
    chk("rst_tick", Tick,      1'b0);
    chk("rst_ack",  Div_ack,   1'b0);
    chk("rst_busy", Div_busy,  1'b0);

    // Reset divisor 4: 1,1,0,0 from the first edge after release.
    Reset_n = 1'b1; Enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("n4_clk%0d", i),  Clock_out, (i % 4) < 2);
      chk($sformatf("n4_tick%0d", i), Tick,      (i % 4) == 0);
    end

    // Load 5 (lands on a wrap with nothing pending, so it only goes pending).
    Div_value = 5; Div_load = 1'b1;
    step();
    chk("ld5_busy", Div_busy, 1'b1);
    chk("ld5_ack",  Div_ack,  1'b0);
    chk("ld5_tick", Tick,     1'b1);
    Div_load = 1'b0; Restart = 1'b1;
    step();
    chk("rs5_ack",  Div_ack,   1'b1);
    chk("rs5_busy", Div_busy,  1'b0);
    chk("rs5_clk",  Clock_out, 1'b0);
    chk("rs5_tick", Tick,      1'b0);
    Restart = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("n5_clk%0d", i),  Clock_out, (i % 5) < 3);
      chk($sformatf("n5_tick%0d", i), Tick,      (i % 5) == 0);
      chk($sformatf("n5_ack%0d", i),  Div_ack,   1'b0);
    end

    // Load together with Restart: nothing applied, 8 becomes pending.
    Div_value = 8; Div_load = 1'b1; Restart = 1'b1;
    step();
    chk("rsld_ack",  Div_ack,  1'b0);
    chk("rsld_busy", Div_busy, 1'b1);
    Div_load = 1'b0;
    step();
    chk("rs8_ack", Div_ack, 1'b1);
    Restart = 1'b0;
    step();
    chk("n8_tick", Tick, 1'b1);
    step();                       // cnt now 1
    Div_value = 3; Div_load = 1'b1;
    e_clk  = 12'b110000_110110;
    e_tick = 12'b000000_100100;
    e_ack  = 12'b000000_100000;
    e_busy = 12'b111111_000000;
    busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      Div_load = 1'b0;
      if (Div_busy) busy_cnt++;
      chk($sformatf("n83_clk%0d", k),  Clock_out, e_clk[11-k]);
      chk($sformatf("n83_tick%0d", k), Tick,      e_tick[11-k]);
      chk($sformatf("n83_ack%0d", k),  Div_ack,   e_ack[11-k]);
      chk($sformatf("n83_busy%0d", k), Div_busy,  e_busy[11-k]);
    end
    chki("n83_busy_len", busy_cnt, 6);

    // Load 0 then 1 back to back: one ack, period 2. cnt is 2 here (N=3).
    Div_value = 0; Div_load = 1'b1;
    step();
    chk("ld0_busy", Div_busy, 1'b1);
    chk("ld0_ack",  Div_ack,  1'b0);
    Div_value = 1;
    step();
    chk("ld1_busy", Div_busy, 1'b1);
    Div_load = 1'b0;
    step();
    chk("ld1_ack_wait", Div_ack, 1'b0);
    step();
    chk("n2_ack",  Div_ack,  1'b1);
    chk("n2_tick", Tick,     1'b1);
    chk("n2_busy", Div_busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("n2_clk%0d", i),  Clock_out, (i % 2) == 1);
      chk($sformatf("n2_tick%0d", i), Tick,      (i % 2) == 1);
      chk($sformatf("n2_ack%0d", i),  Div_ack,   1'b0);
    end

    // N=6, Enable low for 3 cycles inside the high phase.
    Div_value = 6; Div_load = 1'b1;
    step();
    Div_load = 1'b0; Restart = 1'b1;
    step();
    chk("rs6_ack", Div_ack, 1'b1);
    Restart = 1'b0;
    step();
    chk("n6_tick", Tick, 1'b1);
    per = 0; hi = 0;
    step(); per++; if (Clock_out) hi++;
    Enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); per++; if (Clock_out) hi++;
      chk($sformatf("en0_clk%0d", i),  Clock_out, 1'b1);
      chk($sformatf("en0_tick%0d", i), Tick,      1'b0);
    end
    Enable = 1'b1;
    do begin step(); per++; if (Clock_out) hi++; end while (!Tick && per < 40);
    chki("stretch_per", per, 9);
    chki("stretch_hi",  hi,  6);
    per = 0; hi = 0;
    do begin step(); per++; if (Clock_out) hi++; end while (!Tick && per < 40);
    chki("n6_per", per, 6);
    chki("n6_hi",  hi,  3);

    // Reset mid-period with a load pending.
    step();
    Div_value = 9; Div_load = 1'b1;
    step();
    Div_load = 1'b0;
    chk("pre_rst_busy", Div_busy, 1'b1);
    step();
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_clk",  Clock_out, 1'b0);
    chk("arst_tick", Tick,      1'b0);
    chk("arst_ack",  Div_ack,   1'b0);
    chk("arst_busy", Div_busy,  1'b0);
    step();
    Reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("r4_clk%0d", i),  Clock_out, (i % 4) < 2);
      chk($sformatf("r4_tick%0d", i), Tick,      (i % 4) == 0);
      chk($sformatf("r4_ack%0d", i),  Div_ack,   1'b0);
      chk($sformatf("r4_busy%0d", i), Div_busy,  1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
# clock_divider_prog

Programmable, parametrised clock divider for the VGA controller. It derives a divided clock `Clock_out` and a one-cycle enable `Tick` from `Clock_in` (100 MHz board clock), using a divisor that can be changed at runtime. Divisor changes take effect only at period boundaries, so the output never glitches. Downstream pixel and sync logic runs on `Clock_in` and uses `Tick` as its clock enable. `Clock_out` is for observation and off-chip use.

## Interface
- `WIDTH`, 16: width of the counter and the divisor.
- `RESET_DIV`, 4: divisor in force after reset. Clamped like `Div_value`.
- `Clock_in`  in  1  system clock; all logic is on its rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Enable`  in  1  count enable. When low, the divider freezes.
- `Restart`  in  1  synchronous re-phase of the divider.
- `Div_value`  in  WIDTH  requested period N, in `Clock_in` cycles.
- `Div_load`  in  1  capture `Div_value` as the pending divisor.
- `Div_busy`  out  1  a pending divisor is waiting to be applied.
- `Div_ack`  out  1  one-cycle pulse when the pending divisor takes effect.
- `Clock_out`  out  1  divided clock, period N_act.
- `Tick`  out  1  one-cycle pulse on the first cycle of each period.

## Operation
- **Divisor clamp.** Any divisor value of 0 or 1 is treated as 2. Legal N range is 2 .. 2^WIDTH-1.
- **Registers.** `cnt` (WIDTH bits), `n_act` (active divisor), `n_pend` (pending divisor), `pend` (pending flag).
- **Counting.** On each edge with `Enable`=1:
  - if `cnt` == `n_act`-1, `cnt` wraps to 0 (the wrap event);
  - otherwise `cnt` increments by 1.
- **High-phase length.** H = `n_act` - (`n_act` >> 1), i.e. ceil(N/2). For odd N the high phase is one cycle longer than the low phase.
- **Outputs.** All outputs are registered and track the new `cnt` value:
  - `Clock_out` = (`cnt` < H);
  - `Tick` = (`cnt` == 0) AND `Enable`, so `Tick` coincides with each rising edge of `Clock_out`.
- **Enable low.** `cnt`, `Clock_out`, `n_act` and `pend` hold their values. `Tick`=0 and `Div_ack`=0.
- **Divisor load.**
  - `Div_load`=1 captures the clamped `Div_value` into `n_pend` and sets `pend`.
  - A second load while `pend`=1 overwrites `n_pend`; the last load wins.
- **Applying the pending divisor.** At a wrap event with `pend`=1 (value held before that edge):
  - `n_act` <= `n_pend`, `pend` <= 0, and `Div_ack`=1 in the same cycle as `Tick`.
  - The new period starts at that wrap; its H is computed from the new `n_act`.
- **Load coinciding with a wrap.** If `Div_load` and a wrap fall on the same edge, the wrap applies any already-pending value. The newly loaded value becomes pending and applies at the following wrap.
- **Restart.** `Restart`=1 (priority over `Enable`):
  - applies any pending divisor immediately (`Div_ack`=1 only if `pend` was set);
  - sets `cnt` <= new `n_act`-1, `Clock_out` <= 0, `Tick` <= 0.
  - The next enabled edge starts a fresh period.
  - A `Div_load` on the same edge as `Restart` is captured as pending after the restart.
- **Reset** (asynchronous, `Reset_n`=0):
  - `n_act` = clamp(`RESET_DIV`), `cnt` = `n_act`-1, `pend`=0;
  - `Clock_out`=0, `Tick`=0, `Div_ack`=0, `Div_busy`=0.
  - Asserting reset mid-period discards any pending divisor.
- `Div_busy` = `pend`.

## Timing
- Single clock domain. No combinational path from any input to any output.
- First enabled edge after reset release: `Clock_out`=1 and `Tick`=1.
- Output period is N_act cycles: `Clock_out` high for H cycles, low for N-H cycles. `Tick` spacing is N_act while `Enable` stays high.
- Divisor latency: from `Div_load` to `Div_ack` is between 1 and N_act cycles; it always lands on a period boundary.
- `Div_busy` rises the cycle after `Div_load` and falls in the same cycle that `Div_ack` is high.
- With `Enable` low for k cycles, the current period stretches by exactly k cycles.

## Test plan
- Reset with `RESET_DIV`=4, hold `Enable`=1 -> `Clock_out` reads 1,1,0,0 repeating. `Tick` is high on each first 1. First rise occurs on the first edge after `Reset_n` goes high.
- Load N=5 then `Restart` -> `Clock_out` is high for 3 cycles and low for 2. `Tick` spacing is 5. `Div_ack` pulses once.
- Running with N=8, load N=3 at `cnt`=2 -> the 8-cycle period completes. `Div_ack` and `Tick` occur together. The next periods are high 2, low 1. `Div_busy` is high for 6 cycles.
- Load `Div_value`=0, then `Div_value`=1 in consecutive cycles -> a single `Div_ack`. The resulting period is 2 (1 high, 1 low).
- Drop `Enable` for 3 cycles during a high phase at N=6 -> `Clock_out` holds 1 and no `Tick` occurs. That period measures 9 cycles; later periods measure 6.
- Assert `Reset_n`=0 mid-period with a load pending -> all outputs go to 0 immediately. `Div_busy`=0, and the divider resumes with `RESET_DIV` timing.
